// File: rtl/win_addr_gen.sv
// KxK sliding-window word-address generator for a square image stored in DDR3 bursts.
// Optional feature: define WIN_ADDR_GEN_ABORT_EN to add an abort input that cancels a running scan.
module win_addr_gen #(
  parameter int WIN_SIZE = 3,
  parameter int WORD_LEN = 32,
  parameter int ADDR_W   = 28,
  parameter int EDGE_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef WIN_ADDR_GEN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [EDGE_W-1:0] img_edge,
  input  logic [2:0]        stride,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
);

  localparam int BEAT   = 2048 / WORD_LEN;
  localparam int BEAT_W = $clog2(BEAT) + 1;
  localparam int PIX_W  = 2 * EDGE_W + 2;
  localparam int SUM_W  = ((ADDR_W > PIX_W + BEAT_W) ? ADDR_W : PIX_W + BEAT_W) + 1;
  localparam int EXT_W  = EDGE_W + 2;
  localparam logic [1:0] KLAST = 2'(WIN_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [EDGE_W-1:0] edge_q;
  logic [2:0]        stride_q;
  logic [EDGE_W-1:0] ptr_q, ptr_d, ptc_q, ptc_d;
  logic [1:0]        bd_q, bd_d, bm_q, bm_d;
  logic              finWait_q, finWait_d;

  logic              accept, fire, abortHit, fitsNow;
  logic              colFits, rowFits, beatWrap, lastBeat;
  logic [EXT_W-1:0]  nextCol, nextRow;
  logic [PIX_W-1:0]  pixRow, pixCol, pixIdx;
  logic [SUM_W-1:0]  fullAddr;

`ifdef WIN_ADDR_GEN_ABORT_EN
  assign abortHit = (state_q == RUN) && abort;
`else
  assign abortHit = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && start;
  assign fire     = (state_q == RUN) && addr_ready && !abortHit;
  assign fitsNow  = (EXT_W'(img_edge) + EXT_W'(1)) >= EXT_W'(WIN_SIZE);

  assign nextCol  = EXT_W'(ptc_q) + EXT_W'(stride_q);
  assign nextRow  = EXT_W'(ptr_q) + EXT_W'(stride_q);
  assign colFits  = (nextCol + EXT_W'(WIN_SIZE - 1)) <= EXT_W'(edge_q);
  assign rowFits  = (nextRow + EXT_W'(WIN_SIZE - 1)) <= EXT_W'(edge_q);
  assign beatWrap = (bm_q == KLAST) && (bd_q == KLAST);
  assign lastBeat = beatWrap && !colFits && !rowFits;

  // Address is rebuilt from the coordinates every cycle, so a stall can never drift it.
  always_comb begin
    pixRow   = PIX_W'(ptr_q) + PIX_W'(bd_q);
    pixCol   = PIX_W'(ptc_q) + PIX_W'(bm_q);
    pixIdx   = pixRow * (PIX_W'(edge_q) + PIX_W'(1)) + pixCol;
    fullAddr = SUM_W'(base_q) + SUM_W'(pixIdx) * SUM_W'(BEAT);
  end

  always_comb begin
    ptr_d = ptr_q;
    ptc_d = ptc_q;
    bd_d  = bd_q;
    bm_d  = bm_q;
    if (bm_q != KLAST) begin
      bm_d = bm_q + 2'd1;
    end else begin
      bm_d = '0;
      if (bd_q != KLAST) begin
        bd_d = bd_q + 2'd1;
      end else begin
        bd_d = '0;
        if (colFits) begin
          ptc_d = EDGE_W'(nextCol);
        end else begin
          ptc_d = '0;
          if (rowFits) ptr_d = EDGE_W'(nextRow);
        end
      end
    end
  end

  // A window that does not fit spends one extra FIN cycle before done.
  assign finWait_d = accept && !fitsNow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      edge_q    <= '0;
      stride_q  <= '0;
      ptr_q     <= '0;
      ptc_q     <= '0;
      bd_q      <= '0;
      bm_q      <= '0;
      finWait_q <= 1'b0;
    end else begin
      finWait_q <= finWait_d;
      if (accept) begin
        base_q   <= base_addr;
        edge_q   <= img_edge;
        stride_q <= (stride == 3'd0) ? 3'd1 : stride;
        ptr_q    <= '0;
        ptc_q    <= '0;
        bd_q     <= '0;
        bm_q     <= '0;
      end else if (fire) begin
        ptr_q <= ptr_d;
        ptc_q <= ptc_d;
        bd_q  <= bd_d;
        bm_q  <= bm_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = fitsNow ? RUN : FIN;
      RUN: begin
        if (abortHit)               state_d = IDLE;
        else if (fire && lastBeat)  state_d = FIN;
      end
      FIN:     if (!finWait_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_valid = (state_q == RUN);
    busy       = (state_q != IDLE);
    done       = (state_q == FIN) && !finWait_q;
    addr       = addr_valid ? ADDR_W'(fullAddr) : '0;
  end

endmodule

// File: tb/tb_win_addr_gen.sv
// Directed self-checking bench for win_addr_gen (WIN_SIZE=3, WORD_LEN=32 -> 64 words per pixel).
// Define WIN_ADDR_GEN_ABORT_EN to also exercise the abort scenario.
module tb_win_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [27:0] base_addr;
  logic [5:0]  img_edge;
  logic [2:0]  stride;
  logic [27:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic        busy;
  logic        done;
  logic        abort;

  int errors = 0;
  int checks = 0;
  logic [27:0] expQ[$];

  win_addr_gen #(.WIN_SIZE(3), .WORD_LEN(32), .ADDR_W(28), .EDGE_W(6)) dut (
`ifdef WIN_ADDR_GEN_ABORT_EN
    .abort(abort),
`endif
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .img_edge(img_edge),
    .stride(stride),
    .addr(addr),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .busy(busy),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference sequence: row-major origins, then the 3x3 offsets, 64 words per pixel.
  function automatic void buildExp(input logic [27:0] b, input int e, input int s);
    int v;
    expQ.delete();
    if (s == 0) s = 1;
    for (int r = 0; r + 2 <= e; r += s)
      for (int c = 0; c + 2 <= e; c += s)
        for (int k = 0; k < 9; k++) begin
          v = ((r + k / 3) * (e + 1) + c + k % 3) * 64;
          expQ.push_back(b + 28'(v));
        end
  endfunction

  task automatic applyStimulus(input logic [27:0] b, input logic [5:0] e, input logic [2:0] s);
    base_addr = b;
    img_edge  = e;
    stride    = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (addr !== 28'h0) begin errors++; $display("[TB] FAIL reset_addr got=%h want=0", addr); end
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", addr_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_continuous();
    logic [27:0] got[$];
    buildExp(28'h100, 3, 1);
    addr_ready = 1'b1;
    applyStimulus(28'h100, 6'd3, 3'd1);
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (addr_valid !== 1'b1 || addr !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL cont_addr[%0d] got valid=%b addr=%h want valid=1 addr=%h", i, addr_valid, addr, expQ[i]);
      end
      got.push_back(addr);
      tick();
    end
    checks++; if (got[0] !== 28'h100) begin errors++; $display("[TB] FAIL cont_first got=%h want=100", got[0]); end
    checks++; if (got[1] !== 28'h140) begin errors++; $display("[TB] FAIL cont_second got=%h want=140", got[1]); end
    checks++; if (got[2] !== 28'h180) begin errors++; $display("[TB] FAIL cont_third got=%h want=180", got[2]); end
    checks++; if (got[3] !== 28'h200) begin errors++; $display("[TB] FAIL cont_fourth got=%h want=200", got[3]); end
    checks++; if (got[35] !== 28'h4C0) begin errors++; $display("[TB] FAIL cont_last got=%h want=4c0", got[35]); end
    checks++;
    if (addr_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cont_done got valid=%b done=%b want valid=0 done=1", addr_valid, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cont_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [27:0] rec[$];
    int stall = 0;
    int doneCnt = 0;
    bit seenDone = 0;
    buildExp(28'h100, 3, 1);
    addr_ready = 1'b1;
    applyStimulus(28'h100, 6'd3, 3'd1);
    for (int cyc = 0; cyc < 200 && !seenDone; cyc++) begin
      if (done === 1'b1) begin
        seenDone = 1;
        doneCnt++;
      end else if (addr_valid === 1'b1) begin
        if (rec.size() == 1 && stall < 5) begin
          addr_ready = 1'b0;
          stall++;
          checks++;
          if (addr !== 28'h140) begin errors++; $display("[TB] FAIL bp_hold[%0d] got=%h want=140", stall, addr); end
        end else begin
          addr_ready = 1'b1;
          rec.push_back(addr);
        end
      end
      tick();
    end
    addr_ready = 1'b1;
    checks++; if (!seenDone) begin errors++; $display("[TB] FAIL bp_timeout got no done want done within 200 cycles"); end
    checks++; if (stall != 5) begin errors++; $display("[TB] FAIL bp_stalls got=%0d want=5", stall); end
    checks++; if (rec.size() != 36) begin errors++; $display("[TB] FAIL bp_count got=%0d want=36", rec.size()); end
    for (int i = 0; i < rec.size() && i < expQ.size(); i++) begin
      checks++;
      if (rec[i] !== expQ[i]) begin errors++; $display("[TB] FAIL bp_seq[%0d] got=%h want=%h", i, rec[i], expQ[i]); end
    end
    tick();
  endtask

  task automatic test_nofit();
    addr_ready = 1'b1;
    applyStimulus(28'h100, 6'd1, 3'd1);
    checks++;
    if (addr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nofit_c1 got valid=%b done=%b busy=%b want 0 0 1", addr_valid, done, busy);
    end
    tick();
    checks++;
    if (addr_valid !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nofit_c2 got valid=%b done=%b want valid=0 done=1", addr_valid, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nofit_c3 got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_stride();
    logic [27:0] last;
    last = '0;
    buildExp(28'h0, 4, 2);
    addr_ready = 1'b1;
    applyStimulus(28'h0, 6'd4, 3'd2);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (addr_valid !== 1'b1 || addr !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL stride_addr[%0d] got valid=%b addr=%h want valid=1 addr=%h", i, addr_valid, addr, expQ[i]);
      end
      last = addr;
      tick();
    end
    checks++; if (expQ.size() != 36) begin errors++; $display("[TB] FAIL stride_model_len got=%0d want=36", expQ.size()); end
    checks++; if (last !== 28'h600) begin errors++; $display("[TB] FAIL stride_last got=%h want=600", last); end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL stride_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_reset_midrun();
    logic [27:0] rec[$];
    bit seenDone = 0;
    addr_ready = 1'b1;
    applyStimulus(28'h100, 6'd3, 3'd1);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (addr !== 28'h0 || addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_out got addr=%h valid=%b busy=%b done=%b want all 0", addr, addr_valid, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_quiet[%0d] got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    buildExp(28'h100, 3, 1);
    applyStimulus(28'h100, 6'd3, 3'd1);
    for (int cyc = 0; cyc < 100 && !seenDone; cyc++) begin
      if (cyc == 3) begin start = 1'b1; base_addr = 28'h800; end
      if (cyc == 6) start = 1'b0;
      if (done === 1'b1) seenDone = 1;
      else if (addr_valid === 1'b1) rec.push_back(addr);
      tick();
    end
    start = 1'b0;
    checks++; if (!seenDone) begin errors++; $display("[TB] FAIL busystart_timeout got no done want done"); end
    checks++; if (rec.size() != 36) begin errors++; $display("[TB] FAIL busystart_count got=%0d want=36", rec.size()); end
    for (int i = 0; i < rec.size() && i < expQ.size(); i++) begin
      checks++;
      if (rec[i] !== expQ[i]) begin errors++; $display("[TB] FAIL busystart_seq[%0d] got=%h want=%h", i, rec[i], expQ[i]); end
    end
    checks++;
    if (busy !== 1'b0 || addr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busystart_after got busy=%b valid=%b want 0 0", busy, addr_valid);
    end
  endtask

  task automatic test_back_to_back();
    addr_ready = 1'b1;
    applyStimulus(28'h100, 6'd1, 3'd1);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done got=%b want=1", done); end
    tick();
    applyStimulus(28'h200, 6'd3, 3'd1);
    checks++;
    if (addr_valid !== 1'b1 || addr !== 28'h200) begin
      errors++;
      $display("[TB] FAIL b2b_restart got valid=%b addr=%h want valid=1 addr=200", addr_valid, addr);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef WIN_ADDR_GEN_ABORT_EN
  task automatic test_abort();
    buildExp(28'h100, 3, 1);
    addr_ready = 1'b1;
    applyStimulus(28'h100, 6'd3, 3'd1);
    repeat (10) tick();
    checks++; if (addr !== expQ[10]) begin errors++; $display("[TB] FAIL abort_at10 got=%h want=%h", addr, expQ[10]); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_stop got valid=%b busy=%b done=%b want 0 0 0", addr_valid, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_nodone[%0d] got=%b want=0", i, done); end
    end
    applyStimulus(28'h100, 6'd3, 3'd1);
    checks++;
    if (addr_valid !== 1'b1 || addr !== 28'h100) begin
      errors++;
      $display("[TB] FAIL abort_restart got valid=%b addr=%h want valid=1 addr=100", addr_valid, addr);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    img_edge   = '0;
    stride     = '0;
    addr_ready = 1'b0;
    abort      = 1'b0;
    repeat (2) tick();
    test_reset();
    test_continuous();
    test_backpressure();
    test_nofit();
    test_stride();
    test_reset_midrun();
    test_back_to_back();
`ifdef WIN_ADDR_GEN_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/win_addr_gen.md
WIN_ADDR_GEN -- requirements
Module: win_addr_gen

Interface
REQ-001 Parameter WIN_SIZE, default 3: window edge K; the window is KxK, legal range 2..4.
REQ-002 Parameter WORD_LEN, default 32: DDR3 word length in bits.
REQ-003 Parameter ADDR_W, default 28: address width.
REQ-004 Parameter EDGE_W, default 6: image-edge field width.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-008 base_addr  in  ADDR_W  image base address; latched when start is accepted.
REQ-009 img_edge  in  EDGE_W  image side length minus 1; the image is square; latched when start is accepted.
REQ-010 stride  in  3  window-origin step; latched when start is accepted; a value of 0 is treated as 1.
REQ-011 addr  out  ADDR_W  generated word address.
REQ-012 addr_valid  out  1  addr holds a valid address.
REQ-013 addr_ready  in  1  consumer accepts addr when addr_valid and addr_ready are both high.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse marking the end of the scan.

Function
REQ-016 The FSM SHALL have three states, IDLE, RUN and FIN; start in IDLE moves to RUN, or to FIN if the window does not fit the image.
REQ-017 Window fit SHALL be judged as: the window fits when img_edge+1 >= WIN_SIZE; if it does not fit, zero addresses are emitted and done pulses in the cycle after FIN is entered.
REQ-018 In RUN, window origins (ptr, ptc) SHALL be scanned row-major from (0,0); each coordinate steps by stride while coordinate+WIN_SIZE-1 <= img_edge.
REQ-019 For each origin, offsets b = 0..K*K-1 SHALL be issued in order, with row offset bd = b div K and column offset bm = b mod K.
REQ-020 addr SHALL equal base + ((ptr+bd)*(img_edge+1) + (ptc+bm)) * BEAT, where BEAT = 2048/WORD_LEN; the result is computed absolutely, not by accumulation, and truncated to ADDR_W.
REQ-021 Intermediate products SHALL be sized to hold the full result without overflow before the final truncation.
REQ-022 addr_valid SHALL rise in the cycle after start is accepted.
REQ-023 While addr_valid=1 and addr_ready=0, addr SHALL stay stable and addr_valid SHALL stay high.
REQ-024 Each handshake SHALL advance to the next address with no bubble, giving one address per cycle under continuous ready.
REQ-025 On acceptance of the last address, the FSM SHALL go to FIN; addr_valid SHALL drop in the next cycle, and done SHALL pulse in that same cycle, then the FSM returns to IDLE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 A new start SHALL be accepted in the cycle after done.
REQ-028 A changing addr_ready SHALL never cause an address to be skipped or duplicated.

Reset
REQ-029 When rst_n=0 at a clock edge, the state SHALL become IDLE and addr, addr_valid, busy and done SHALL all be 0.
REQ-030 All counters and latched inputs SHALL clear to 0 on reset.
REQ-031 Reset during RUN SHALL abandon the scan with no done pulse.

Configuration
REQ-032 With macro WIN_ADDR_GEN_ABORT_EN defined, the block SHALL have an extra input abort (1 bit).
REQ-033 With the macro defined, abort=1 in RUN SHALL force IDLE at the next edge, drop addr_valid and emit no done; abort SHALL have priority over a simultaneous handshake.
REQ-034 With the macro undefined, the abort port and its logic SHALL be absent and a scan always runs to completion.

Verification
REQ-035 WIN_SIZE=3, WORD_LEN=32, base=0x100, img_edge=3, stride=1, ready held high -> 36 addresses in 36 consecutive cycles; first four are 0x100, 0x140, 0x180, 0x200; last is 0x100+15*64=0x4C0; then one done pulse.
REQ-036 Same setup with ready low for 5 cycles on the 2nd address -> addr stays 0x140 with valid high for 5 cycles; the full sequence still has 36 entries with no duplicates.
REQ-037 img_edge=1, WIN_SIZE=3 -> no addr_valid; done pulses exactly 2 cycles after start.
REQ-038 img_edge=4, stride=2, base=0 -> origins (0,0),(0,2),(2,0),(2,2); 36 addresses; last is (4*5+4)*64=0x600.
REQ-039 rst_n low for one cycle mid-RUN, then start asserted while busy is still high in a separate run -> after reset all outputs are 0 with no done; the start issued while busy is ignored.
REQ-040 With WIN_ADDR_GEN_ABORT_EN defined, abort at address 10 -> valid drops next cycle, no done, busy=0, and a following start restarts at base.
